// File: rtl/blow_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : blow_input_conditioner_if
// Purpose  : Pin-side and game-side signals of the blow input conditioner.
// Revision : 1.0 - initial release
// ============================================================================
interface blow_input_conditioner_if #(
    parameter int STRENGTH_W = 8
);
    logic                  frame;
    logic                  sensor_n;
    logic                  manual_n;
    logic                  manual_sel;
    logic                  blow;
    logic                  blow_rise;
    logic [STRENGTH_W-1:0] blow_strength;
    logic                  sensor_level;

    modport master (
        output frame, sensor_n, manual_n, manual_sel,
        input  blow, blow_rise, blow_strength, sensor_level
    );

    modport slave (
        input  frame, sensor_n, manual_n, manual_sel,
        output blow, blow_rise, blow_strength, sensor_level
    );
endinterface
`default_nettype wire

// File: rtl/blow_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : blow_input_conditioner
// Purpose  : Synchronise/debounce sensor and key, select one, frame-align it.
// Revision : 1.0 - initial release
// ============================================================================
module blow_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STRENGTH_W      = 8
) (
    input  wire logic               clock,
    input  wire logic               reset,
    blow_input_conditioner_if.slave bus
);
    localparam int               CNT_W          = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_DEB_TARGET   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);
    localparam bit               c_ONE_DONE     = (DEBOUNCE_CYCLES <= 1);
    localparam logic [1:0]       c_IDLE         = 2'd0;
    localparam logic [1:0]       c_PRESS_WAIT   = 2'd1;
    localparam logic [1:0]       c_ACTIVE       = 2'd2;
    localparam logic [1:0]       c_RELEASE_WAIT = 2'd3;
    localparam logic [STRENGTH_W-1:0] c_STR_MAX = '1;

    logic [1:0]            r_sensor_sync;
    logic [1:0]            r_manual_sync;
    logic [1:0]            r_sel_sync;
    logic [1:0]            w_raw_active;
    logic [1:0]            w_deb_level;
    logic                  w_act_nxt;
    logic                  w_blow_nxt;
    logic                  r_act;
    logic                  r_seen;
    logic                  r_blow;
    logic                  r_blow_rise;
    logic [STRENGTH_W-1:0] r_strength;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sensor_sync <= 2'b11;
            r_manual_sync <= 2'b11;
            r_sel_sync    <= 2'b00;
        end else begin
            r_sensor_sync <= {r_sensor_sync[0], bus.sensor_n};
            r_manual_sync <= {r_manual_sync[0], bus.manual_n};
            r_sel_sync    <= {r_sel_sync[0], bus.manual_sel};
        end
    end

    // Index 0 = sensor, index 1 = key; active-high after inversion.
    assign w_raw_active = {~r_manual_sync[1], ~r_sensor_sync[1]};

    genvar k;
    generate
        for (k = 0; k < 2; k++) begin : g_deb
            logic [1:0]       r_state;
            logic [1:0]       w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic [CNT_W-1:0] w_cnt_inc;
            logic             w_low;
            logic             w_level;

            assign w_low     = w_raw_active[k];
            assign w_cnt_inc = r_cnt + c_CNT_ONE;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            // The edge that leaves a stable state already counts as the first
            // stable cycle of the new level; the count never exceeds the target.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = '0;
                case (r_state)
                    c_IDLE: begin
                        if (w_low) begin
                            w_state_nxt = c_ONE_DONE ? c_ACTIVE : c_PRESS_WAIT;
                            w_cnt_nxt   = c_ONE_DONE ? '0 : c_CNT_ONE;
                        end
                    end
                    c_PRESS_WAIT: begin
                        if (!w_low) begin
                            w_state_nxt = c_IDLE;
                        end else if (w_cnt_inc == c_DEB_TARGET) begin
                            w_state_nxt = c_ACTIVE;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                    c_ACTIVE: begin
                        if (!w_low) begin
                            w_state_nxt = c_ONE_DONE ? c_IDLE : c_RELEASE_WAIT;
                            w_cnt_nxt   = c_ONE_DONE ? '0 : c_CNT_ONE;
                        end
                    end
                    c_RELEASE_WAIT: begin
                        if (w_low) begin
                            w_state_nxt = c_ACTIVE;
                        end else if (w_cnt_inc == c_DEB_TARGET) begin
                            w_state_nxt = c_IDLE;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                    default: w_state_nxt = c_IDLE;
                endcase
            end

            always_comb begin
                w_level = (r_state == c_ACTIVE) || (r_state == c_RELEASE_WAIT);
            end

            assign w_deb_level[k] = w_level;
        end
    endgenerate

    assign w_act_nxt  = r_sel_sync[1] ? w_deb_level[1] : w_deb_level[0];
    assign w_blow_nxt = r_seen | r_act;

    // Activity present on a frame edge is counted in both adjacent windows.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_act       <= 1'b0;
            r_seen      <= 1'b0;
            r_blow      <= 1'b0;
            r_blow_rise <= 1'b0;
            r_strength  <= '0;
        end else begin
            r_act       <= w_act_nxt;
            r_blow_rise <= 1'b0;
            if (bus.frame) begin
                r_blow      <= w_blow_nxt;
                r_seen      <= r_act;
                r_blow_rise <= w_blow_nxt & ~r_blow;
                if (!w_blow_nxt) begin
                    r_strength <= '0;
                end else if (r_strength != c_STR_MAX) begin
                    r_strength <= r_strength + 1'b1;
                end
            end else begin
                r_seen <= r_seen | r_act;
            end
        end
    end

    assign bus.blow          = r_blow;
    assign bus.blow_rise     = r_blow_rise;
    assign bus.blow_strength = r_strength;
    assign bus.sensor_level  = w_deb_level[0];
endmodule
`default_nettype wire

// File: tb/tb_blow_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_blow_input_conditioner
// Purpose  : Self-checking bench for blow_input_conditioner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blow_input_conditioner;
    localparam int D  = 4;
    localparam int SW = 8;
    localparam int FP = 50;

    logic clock = 1'b0;
    logic reset = 1'b1;

    blow_input_conditioner_if #(.STRENGTH_W(SW)) bus ();

    blow_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .STRENGTH_W     (SW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          blow;
        logic          rise;
        logic [SW-1:0] str;
        logic          lvl;
    } exp_t;

    typedef struct {
        string name;
        bit    sel;
        int    s_low;
        int    m_low;
        bit    glitch;
        bit    exp_b1;
        bit    exp_b2;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference state: sync flops, debounced levels with run lengths, window.
    logic          m_sen_s1, m_sen_s2, m_man_s1, m_man_s2, m_sel_s1, m_sel_s2;
    logic [1:0]    m_lvl;
    int            m_run [2];
    logic          m_act, m_seen, m_blow, m_rise;
    logic [SW-1:0] m_str;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_sen_s1 = 1'b1; m_sen_s2 = 1'b1;
        m_man_s1 = 1'b1; m_man_s2 = 1'b1;
        m_sel_s1 = 1'b0; m_sel_s2 = 1'b0;
        m_lvl = 2'b00; m_run[0] = 0; m_run[1] = 0;
        m_act = 1'b0; m_seen = 1'b0; m_blow = 1'b0; m_rise = 1'b0; m_str = '0;
    endtask

    task automatic model_step();
        logic [1:0]    syn;
        logic [1:0]    n_lvl;
        int            n_run [2];
        logic          n_act, nb, n_seen, n_blow, n_rise;
        logic [SW-1:0] n_str;
        exp_t          e;
        syn = {~m_man_s2, ~m_sen_s2};
        for (int i = 0; i < 2; i++) begin
            n_lvl[i] = m_lvl[i];
            n_run[i] = 0;
            if (syn[i] != m_lvl[i]) begin
                if (m_run[i] + 1 >= D) n_lvl[i] = ~m_lvl[i];
                else                   n_run[i] = m_run[i] + 1;
            end
        end
        n_act  = m_sel_s2 ? m_lvl[1] : m_lvl[0];
        n_blow = m_blow;
        n_str  = m_str;
        n_rise = 1'b0;
        if (bus.frame) begin
            nb     = m_seen | m_act;
            n_seen = m_act;
            n_rise = nb & ~m_blow;
            n_blow = nb;
            if (!nb)                             n_str = '0;
            else if (int'(m_str) < (1 << SW) - 1) n_str = m_str + 1'b1;
        end else begin
            n_seen = m_seen | m_act;
        end
        m_sen_s2 = m_sen_s1; m_sen_s1 = bus.sensor_n;
        m_man_s2 = m_man_s1; m_man_s1 = bus.manual_n;
        m_sel_s2 = m_sel_s1; m_sel_s1 = bus.manual_sel;
        m_lvl = n_lvl; m_run[0] = n_run[0]; m_run[1] = n_run[1];
        m_act = n_act; m_seen = n_seen; m_blow = n_blow; m_rise = n_rise; m_str = n_str;
        e.blow = n_blow; e.rise = n_rise; e.str = n_str; e.lvl = n_lvl[0];
        q.push_back(e);
    endtask

    // One clock: drive frame, predict, cross the edge, then compare.
    task automatic tick();
        exp_t e;
        exp_t got;
        bus.frame = (cyc % FP == FP - 1);
        model_step();
        @(posedge clock);
        #1;
        cyc++;
        got = {bus.blow, bus.blow_rise, bus.blow_strength, bus.sensor_level};
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expected entry (cycle %0d)", cyc);
        end else begin
            e = q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL outputs: got blow=%b rise=%b str=%0d lvl=%b, expected blow=%b rise=%b str=%0d lvl=%b (cycle %0d)",
                         got.blow, got.rise, got.str, got.lvl, e.blow, e.rise, e.str, e.lvl, cyc);
            end
        end
    endtask

    task automatic run_to_frame();
        bit f;
        for (int i = 0; i < FP + 2; i++) begin
            f = (cyc % FP == FP - 1);
            tick();
            if (f) return;
        end
        chk("frame_timeout", 0, 1);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("reset_blow", int'(bus.blow), 0);
        chk("reset_rise", int'(bus.blow_rise), 0);
        chk("reset_strength", int'(bus.blow_strength), 0);
        chk("reset_sensor_level", int'(bus.sensor_level), 0);
        model_reset();
        q.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    vec_t vecs [8];
    int   lat;
    int   rises;

    initial begin
        vecs[0] = '{"short_press",     1'b0, 10,  0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"glitch_reject",   1'b0,  0,  0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"manual_source",   1'b1,  0, 20, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{"sensor_unsel",    1'b1, 10,  0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"key_unsel",       1'b0,  0, 20, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"press_d_minus_1", 1'b0,  3,  0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{"press_exactly_d", 1'b0,  4,  0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{"key_exactly_d",   1'b1,  0,  4, 1'b0, 1'b1, 1'b0};

        bus.frame = 1'b0; bus.sensor_n = 1'b1; bus.manual_n = 1'b1; bus.manual_sel = 1'b0;

        // Reset release with the sensor already held.
        bus.sensor_n = 1'b0;
        do_reset();
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            tick();
            if (bus.sensor_level) lat = n;
        end
        chk("t1_level_latency", lat, 6);
        run_to_frame();
        chk("t1_blow", int'(bus.blow), 1);
        chk("t1_rise", int'(bus.blow_rise), 1);
        chk("t1_strength", int'(bus.blow_strength), 1);
        bus.sensor_n = 1'b1;
        for (int i = 0; i < 3; i++) run_to_frame();

        // Per-window vectors starting 10 cycles into a window.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 10; i++) tick();
            bus.manual_sel = vecs[v].sel;
            for (int i = 0; i < 30; i++) begin
                bus.sensor_n = ~((i < vecs[v].s_low) || (vecs[v].glitch && (i % 6) < 3));
                bus.manual_n = ~(i < vecs[v].m_low);
                tick();
            end
            bus.sensor_n = 1'b1;
            bus.manual_n = 1'b1;
            run_to_frame();
            chk({vecs[v].name, "_blow1"}, int'(bus.blow), int'(vecs[v].exp_b1));
            chk({vecs[v].name, "_str1"}, int'(bus.blow_strength), int'(vecs[v].exp_b1));
            run_to_frame();
            chk({vecs[v].name, "_blow2"}, int'(bus.blow), int'(vecs[v].exp_b2));
        end

        // Saturation over 300 frames of continuous hold.
        bus.manual_sel = 1'b0;
        bus.sensor_n   = 1'b0;
        rises = 0;
        for (int f = 1; f <= 300; f++) begin
            run_to_frame();
            if (bus.blow_rise) rises++;
            if (f == 1 || f == 100 || f == 255 || f == 300)
                chk("sat_strength", int'(bus.blow_strength), (f < 255) ? f : 255);
        end
        chk("sat_rise_count", rises, 1);
        bus.sensor_n = 1'b1;
        for (int i = 0; i < 3; i++) run_to_frame();

        // Reset in the middle of a held blow with a key press in progress.
        bus.sensor_n = 1'b0;
        for (int f = 0; f < 7; f++) run_to_frame();
        chk("mid_strength_before", int'(bus.blow_strength), 7);
        for (int i = 0; i < 10; i++) tick();
        bus.manual_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.sensor_n = 1'b1;
        bus.manual_n = 1'b1;
        do_reset();
        for (int i = 0; i < 2; i++) run_to_frame();
        chk("mid_blow_after", int'(bus.blow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
